// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by a RESOLUTION-x oversampling baud tick.
// Samples each bit at its midpoint and flags a low stop bit as a framing error.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int RESOLUTION = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 baudTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxDone,
    output logic                 frameErr
);

    localparam int TW = $clog2(RESOLUTION);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(RESOLUTION / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(RESOLUTION - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            tick     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rxData   <= '0;
            rxDone   <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxDone   <= 1'b0;
            frameErr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        tick  <= '0;
                    end
                end
                START: begin
                    if (baudTick) begin
                        if (tick == HALF_LAST) begin
                            tick <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
                DATA: begin
                    if (baudTick) begin
                        if (tick == FULL_LAST) begin
                            tick  <= '0;
                            shift <= {rx_s, shift[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
                STOP: begin
                    if (baudTick) begin
                        if (tick == FULL_LAST) begin
                            // Leave at mid stop bit so a following start edge is caught.
                            tick     <= '0;
                            state    <= IDLE;
                            rxData   <= shift;
                            rxDone   <= 1'b1;
                            frameErr <= ~rx_s;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 115200 baud at 50 MHz (tick every 27 clk).
// A queue of expected frames is checked against every DUT cycle.
module tb_uart_receiver;

    localparam int TICK = 27;
    localparam int BIT  = 432;

    logic       clk;
    logic       rstN;
    logic       baudTick;
    logic       rx;
    logic [7:0] rxData;
    logic       rxDone;
    logic       frameErr;

    int checks = 0;
    int errors = 0;
    int cnt    = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_data = 8'h00;
    logic       model_fe   = 1'b0;
    logic       last_fe    = 1'b0;
    int         done_cnt   = 0;
    int         done_cyc   = 0;
    int         prev_done  = 0;
    int         start_cyc  = 0;

    uart_receiver #(
        .DATA_BITS (8),
        .RESOLUTION(16)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .baudTick(baudTick),
        .rx      (rx),
        .rxData  (rxData),
        .rxDone  (rxDone),
        .frameErr(frameErr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        cnt <= (cnt == TICK - 1) ? 0 : cnt + 1;
    end

    assign baudTick = (cnt == TICK - 1);

    // Compare process: every cycle the outputs must match the frame queue.
    always @(negedge clk) begin
        if (!rstN) begin
            model_data = 8'h00;
            exp_q.delete();
        end else begin
            model_fe = 1'b0;
            if (rxDone) begin
                done_cnt  = done_cnt + 1;
                prev_done = done_cyc;
                done_cyc  = cyc;
                last_fe   = frameErr;
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_done at cyc %0d: rxData=%h", cyc, rxData);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    model_data = e.d;
                    model_fe   = e.fe;
                end
            end
            checks = checks + 1;
            if (rxData !== model_data) begin
                errors = errors + 1;
                $display("FAIL rxData at cyc %0d: got %h want %h", cyc, rxData, model_data);
            end
            checks = checks + 1;
            if (frameErr !== model_fe) begin
                errors = errors + 1;
                $display("FAIL frameErr at cyc %0d: got %b want %b", cyc, frameErr, model_fe);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, got, got, want, want);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        checks = checks + 1;
        if (got < lo || got > hi) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d want %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Place the start edge 2 clk before a tick edge.
    task automatic align();
        for (int i = 0; i < 2 * TICK; i++) begin
            @(negedge clk);
            if (cnt == TICK - 3) break;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int per, input bit do_align);
        exp_t e;
        e.d  = d;
        e.fe = ~stop;
        if (do_align) align();
        exp_q.push_back(e);
        start_cyc = cyc;
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(d[i], per);
        drive_bit(stop, per);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] v5a;
        int base;
        int t_a;
        v5a  = 8'h5A;
        rstN = 1'b0;
        rx   = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rxData", int'(rxData), 0);
        check("reset_rxDone", int'(rxDone), 0);
        check("reset_frameErr", int'(frameErr), 0);
        rstN = 1'b1;
        @(negedge clk);

        // 1: reset during bit 4 of 0x5A
        align();
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(v5a[i], BIT);
        drive_bit(v5a[4], BIT / 2);
        rstN = 1'b0;
        repeat (4) @(negedge clk);
        rx   = 1'b1;
        rstN = 1'b1;
        drive_bit(1'b1, 20 * BIT);
        check("rst_no_done", done_cnt, 0);
        check("rst_rxData", int'(rxData), 0);
        send_frame(8'h5A, 1'b1, BIT, 1'b1);
        drive_bit(1'b1, BIT);
        check("rst_then_5a", int'(rxData), 'h5A);
        check("rst_then_5a_cnt", done_cnt, 1);

        // 2: single frame with latency check
        base = done_cnt;
        send_frame(8'h55, 1'b1, BIT, 1'b1);
        t_a = start_cyc;
        drive_bit(1'b1, BIT);
        check("single_cnt", done_cnt, base + 1);
        check("single_data", int'(rxData), 'h55);
        check("single_fe", int'(last_fe), 0);
        check_range("single_latency", done_cyc - t_a,
                    BIT * 19 / 2 - TICK - 2, BIT * 19 / 2 + TICK + 2);

        // 3: back-to-back frames
        base = done_cnt;
        send_frame(8'hA5, 1'b1, BIT, 1'b1);
        send_frame(8'h3C, 1'b1, BIT, 1'b0);
        drive_bit(1'b1, BIT);
        check("b2b_cnt", done_cnt, base + 2);
        check("b2b_data", int'(rxData), 'h3C);
        check("b2b_fe", int'(last_fe), 0);
        check_range("b2b_spacing", done_cyc - prev_done, 10 * BIT - 2, 10 * BIT + 2);

        // 4: glitch rejection
        base = done_cnt;
        align();
        drive_bit(1'b0, 3 * TICK);
        drive_bit(1'b1, 5 * BIT);
        check("glitch_no_done", done_cnt, base);
        send_frame(8'h0F, 1'b1, BIT, 1'b1);
        drive_bit(1'b1, BIT);
        check("glitch_then_0f", int'(rxData), 'h0F);
        check("glitch_then_cnt", done_cnt, base + 1);

        // 5: framing error then clean frame
        base = done_cnt;
        send_frame(8'hFF, 1'b0, BIT, 1'b1);
        drive_bit(1'b1, 2 * BIT);
        check("ferr_cnt", done_cnt, base + 1);
        check("ferr_data", int'(rxData), 'hFF);
        check("ferr_flag", int'(last_fe), 1);
        send_frame(8'h81, 1'b1, BIT, 1'b1);
        drive_bit(1'b1, BIT);
        check("after_ferr_data", int'(rxData), 'h81);
        check("after_ferr_flag", int'(last_fe), 0);
        check("after_ferr_cnt", done_cnt, base + 2);

        // 6: baud skew of -3% and +3%
        base = done_cnt;
        send_frame(8'hC3, 1'b1, 419, 1'b1);
        drive_bit(1'b1, BIT);
        check("skew_fast_data", int'(rxData), 'hC3);
        check("skew_fast_fe", int'(last_fe), 0);
        send_frame(8'hC3, 1'b1, 445, 1'b1);
        drive_bit(1'b1, BIT);
        check("skew_slow_data", int'(rxData), 'hC3);
        check("skew_slow_fe", int'(last_fe), 0);
        check("skew_cnt", done_cnt, base + 2);

        check("pending_frames", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
